// File: rtl/value_packer_if.sv
// Stream bundle between the conv filter output, the packer and the
// write-back path. The packer sits on the slave side; the filter/write-back
// pair (or a testbench) uses the master side.
interface value_packer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PACK_NUM   = 2
);
  localparam int W  = DATA_WIDTH / 2;
  localparam int CW = $clog2(PACK_NUM + 1);

  logic                  ivalid;
  logic [W-1:0]          ivalue;
  logic                  ilast;
  logic                  iready;
  logic                  ovalid;
  logic                  oready;
  logic [PACK_NUM*W-1:0] ovalue;
  logic [CW-1:0]         ocount;
  logic                  olast;

  modport master (
    output ivalid, ivalue, ilast, oready,
    input  iready, ovalid, ovalue, ocount, olast
  );

  modport slave (
    input  ivalid, ivalue, ilast, oready,
    output iready, ovalid, ovalue, ocount, olast
  );
endinterface

// File: rtl/value_packer.sv
// value_packer: packs PACK_NUM consecutive narrow signed filter values into
// one wide word (lane 0 in the LSBs). ilast closes a partial word early.
// The output word is registered; iready depends only on the registered
// ovalid and on oready, so back-pressure stalls the filter stream without
// a combinational path from ivalid/ilast.
// Optional feature: define VALUE_PACKER_WORDCNT_EN to add the owords and
// ofull_words handoff counters.
module value_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int PACK_NUM   = 2
) (
  input  logic                clk,
  input  logic                rst,
  value_packer_if.slave       bus
`ifdef VALUE_PACKER_WORDCNT_EN
  ,
  output logic [31:0]         owords,
  output logic [31:0]         ofull_words
`endif
);
  localparam int W  = DATA_WIDTH / 2;
  localparam int CW = $clog2(PACK_NUM + 1);
  localparam logic [CW-1:0] LAST_LANE = CW'(PACK_NUM - 1);

  logic [PACK_NUM*W-1:0] r_acc;
  logic [CW-1:0]         r_cnt;
  logic                  r_ovalid;
  logic [PACK_NUM*W-1:0] r_ovalue;
  logic [CW-1:0]         r_ocount;
  logic                  r_olast;

  logic                  w_iready;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_handoff;
  logic [PACK_NUM*W-1:0] w_merged;

  assign w_iready  = !r_ovalid || bus.oready;
  assign w_accept  = bus.ivalid && w_iready;
  assign w_done    = w_accept && ((r_cnt == LAST_LANE) || bus.ilast);
  assign w_handoff = r_ovalid && bus.oready;

  // Accumulator with the offered value dropped into lane r_cnt; upper lanes
  // are still zero because the accumulator is cleared after every word.
  always_comb begin
    w_merged = r_acc;
    for (int i = 0; i < PACK_NUM; i++) begin
      if (CW'(i) == r_cnt) begin
        w_merged[i*W +: W] = bus.ivalue;
      end
    end
  end

  // Lane counter and accumulator advance only on accepted beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_done) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_merged;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Output word register: load on completion (even while handing off the
  // previous word, so words go back-to-back), otherwise drain on handoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovalid <= 1'b0;
      r_ovalue <= '0;
      r_ocount <= '0;
      r_olast  <= 1'b0;
    end else if (w_done) begin
      r_ovalid <= 1'b1;
      r_ovalue <= w_merged;
      r_ocount <= r_cnt + CW'(1);
      r_olast  <= bus.ilast;
    end else if (w_handoff) begin
      r_ovalid <= 1'b0;
    end
  end

  assign bus.iready = w_iready;
  assign bus.ovalid = r_ovalid;
  assign bus.ovalue = r_ovalue;
  assign bus.ocount = r_ocount;
  assign bus.olast  = r_olast;

`ifdef VALUE_PACKER_WORDCNT_EN
  logic [31:0] r_owords;
  logic [31:0] r_ofull_words;

  // Handoff counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owords      <= '0;
      r_ofull_words <= '0;
    end else if (w_handoff) begin
      r_owords <= r_owords + 32'd1;
      if (r_ocount == CW'(PACK_NUM)) begin
        r_ofull_words <= r_ofull_words + 32'd1;
      end
    end
  end

  assign owords      = r_owords;
  assign ofull_words = r_ofull_words;
`endif
endmodule

// File: tb/tb_value_packer.sv
// Bench for value_packer: two instances (PACK_NUM=2 and PACK_NUM=4, W=8)
// share the same input stream and oready; each is compared every cycle
// against a lane-list reference model.
module tb_value_packer;
  logic clk;
  logic rst;

  logic       d_ivalid;
  logic [7:0] d_ivalue;
  logic       d_ilast;
  logic       d_oready;

  value_packer_if #(.DATA_WIDTH(16), .PACK_NUM(2)) if2 ();
  value_packer_if #(.DATA_WIDTH(16), .PACK_NUM(4)) if4 ();

  assign if2.ivalid = d_ivalid;
  assign if2.ivalue = d_ivalue;
  assign if2.ilast  = d_ilast;
  assign if2.oready = d_oready;
  assign if4.ivalid = d_ivalid;
  assign if4.ivalue = d_ivalue;
  assign if4.ilast  = d_ilast;
  assign if4.oready = d_oready;

`ifdef VALUE_PACKER_WORDCNT_EN
  logic [31:0] w_owords [2];
  logic [31:0] w_ofull  [2];
`endif

  value_packer #(.DATA_WIDTH(16), .PACK_NUM(2)) u_p2 (
    .clk(clk), .rst(rst), .bus(if2)
`ifdef VALUE_PACKER_WORDCNT_EN
    , .owords(w_owords[0]), .ofull_words(w_ofull[0])
`endif
  );

  value_packer #(.DATA_WIDTH(16), .PACK_NUM(4)) u_p4 (
    .clk(clk), .rst(rst), .bus(if4)
`ifdef VALUE_PACKER_WORDCNT_EN
    , .owords(w_owords[1]), .ofull_words(w_ofull[1])
`endif
  );

  logic [31:0] w_ov [2];
  logic [3:0]  w_oc [2];
  logic        w_ol [2];
  logic        w_vld[2];
  logic        w_rdy[2];

  assign w_ov[0]  = {16'h0, if2.ovalue};
  assign w_ov[1]  = if4.ovalue;
  assign w_oc[0]  = {2'b0, if2.ocount};
  assign w_oc[1]  = {1'b0, if4.ocount};
  assign w_ol[0]  = if2.olast;
  assign w_ol[1]  = if4.olast;
  assign w_vld[0] = if2.ovalid;
  assign w_vld[1] = if4.ovalid;
  assign w_rdy[0] = if2.iready;
  assign w_rdy[1] = if4.iready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: pending lanes as a plain list, output word as values.
  int          mn [2] = '{2, 4};
  logic [7:0]  m_buf [2][8];
  int          m_len [2];
  logic        m_valid [2];
  logic [31:0] m_value [2];
  int          m_count [2];
  logic        m_last [2];
`ifdef VALUE_PACKER_WORDCNT_EN
  int          m_words [2];
  int          m_full [2];
`endif

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[inst %0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_len[k]   = 0;
      m_valid[k] = 1'b0;
      m_value[k] = '0;
      m_count[k] = 0;
      m_last[k]  = 1'b0;
`ifdef VALUE_PACKER_WORDCNT_EN
      m_words[k] = 0;
      m_full[k]  = 0;
`endif
    end
  endtask

  task automatic check_outputs(input logic ordy);
    for (int k = 0; k < 2; k++) begin
      chk("iready", k, w_rdy[k], !m_valid[k] || ordy);
      chk("ovalid", k, w_vld[k], m_valid[k]);
      chk("ovalue", k, w_ov[k], m_value[k]);
      chk("ocount", k, w_oc[k], m_count[k]);
      chk("olast",  k, w_ol[k], m_last[k]);
`ifdef VALUE_PACKER_WORDCNT_EN
      chk("owords",      k, w_owords[k], m_words[k]);
      chk("ofull_words", k, w_ofull[k],  m_full[k]);
`endif
    end
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance model.
  task automatic step(input logic v, input logic [7:0] val, input logic l, input logic ordy);
    logic        rdy;
    logic        hand;
    logic [31:0] word;
    d_ivalid = v;
    d_ivalue = val;
    d_ilast  = l;
    d_oready = ordy;
    @(negedge clk);
    check_outputs(ordy);
    for (int k = 0; k < 2; k++) begin
      rdy  = !m_valid[k] || ordy;
      hand = m_valid[k] && ordy;
`ifdef VALUE_PACKER_WORDCNT_EN
      if (hand) begin
        m_words[k]++;
        if (m_count[k] == mn[k]) m_full[k]++;
      end
`endif
      if (v && rdy) begin
        m_buf[k][m_len[k]] = val;
        m_len[k]++;
        if (m_len[k] == mn[k] || l) begin
          word = '0;
          for (int i = 0; i < m_len[k]; i++) word = word | ({24'h0, m_buf[k][i]} << (8 * i));
          m_value[k] = word;
          m_count[k] = m_len[k];
          m_last[k]  = l;
          m_valid[k] = 1'b1;
          m_len[k]   = 0;
        end else if (hand) begin
          m_valid[k] = 1'b0;
        end
      end else if (hand) begin
        m_valid[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    d_ivalid = 1'b0;
    d_oready = 1'b1;
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    check_outputs(1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    d_ivalid = 1'b0;
    d_ivalue = '0;
    d_ilast  = 1'b0;
    d_oready = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Basic pack
    step(1, 8'h12, 0, 1);
    step(1, 8'h34, 0, 1);
    chk("basic_ovalue", 0, w_ov[0], 32'h3412);
    chk("basic_ocount", 0, w_oc[0], 4'd2);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);

    // Streaming
    do_reset();
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 1);
    chk("stream_last_word", 0, w_ov[0], 32'h0807);
    step(0, 8'h00, 0, 1);

    // Partial flush
    do_reset();
    step(1, 8'h80, 0, 1);
    step(1, 8'h7F, 1, 1);
    chk("flush_ovalue", 1, w_ov[1], 32'h00007F80);
    chk("flush_ocount", 1, w_oc[1], 4'd2);
    chk("flush_olast",  1, w_ol[1], 1'b1);
    step(0, 8'h00, 0, 1);

    // Back-pressure
    do_reset();
    step(1, 8'hA1, 0, 1);
    step(1, 8'hA2, 0, 0);
    step(1, 8'hA3, 0, 0);
    step(1, 8'hA4, 0, 0);
    step(1, 8'hA5, 0, 0);
    chk("bp_held", 0, w_ov[0], 32'hA2A1);
    step(1, 8'hA3, 0, 1);
    step(1, 8'hA4, 1, 1);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);

    // Reset mid-word
    do_reset();
    step(1, 8'hAA, 0, 1);
    do_reset();
    step(1, 8'h01, 0, 1);
    step(1, 8'h02, 0, 1);
    chk("rst_mid_word", 0, w_ov[0], 32'h0201);
    step(0, 8'h00, 0, 1);

    // Three full words plus one partial on the two-lane instance
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 8'(8'h40 + i), 0, 1);
    step(1, 8'h55, 1, 1);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
`ifdef VALUE_PACKER_WORDCNT_EN
    chk("cnt_owords", 0, w_owords[0], 32'd4);
    chk("cnt_ofull",  0, w_ofull[0],  32'd3);
`endif

    // Randomized traffic with random back-pressure and ilast
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99, 0) < 70) ? 1'b1 : 1'b0,
           8'($urandom),
           ($urandom_range(99, 0) < 12) ? 1'b1 : 1'b0,
           ($urandom_range(99, 0) < 70) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
